// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types and constants for the cipher datapath
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0] aes_word_t;
  typedef aes_word_t [3:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    EMIT   = 2'd2
  } ark_state_e;

endpackage

// File: rtl/aes_ark_stage.sv
// rtl/aes_ark_stage.sv - AddRoundKey stage: collects 4 state words, XORs with expander key words, streams result
module aes_ark_stage
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic [3:0]  in_round,
  input  logic        key_done,
  output logic [3:0]  key_round_num,
  output logic [1:0]  key_r_index,
  input  logic [31:0] key_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
  output logic        err_round
);

  localparam logic [3:0] NR_W = 4'(NR);

  ark_state_e r_state;
  logic [1:0] r_word_idx;
  logic [1:0] r_emit_idx;
  logic [3:0] r_round_q;
  aes_state_t r_buf;
  logic       r_drop_q;
  logic       r_err_round;

  logic       w_take;
  logic [3:0] w_round_sel;

  // Input side: only IDLE/ACCEPT can take words, and only once the expander has valid keys.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && (r_state == IDLE || r_state == ACCEPT)) begin
      in_ready = key_done;
    end
  end

  assign w_take = in_valid && in_ready;

  // Word 0 is looked up with the incoming round; later words use the latched round.
  // Out-of-range rounds are clamped so the expander is never addressed past its last key.
  always_comb begin
    w_round_sel   = (r_state == IDLE) ? in_round : r_round_q;
    key_round_num = (w_round_sel > NR_W) ? NR_W : w_round_sel;
  end

  // State word 0 (MSBs) pairs with key word 3 (key bits [127:96]).
  assign key_r_index = 2'd3 - r_word_idx;

  assign out_valid = (r_state == EMIT);
  assign out_word  = r_buf[r_emit_idx];
  assign out_last  = (r_state == EMIT) && (r_emit_idx == 2'd3);
  assign err_round = r_err_round;

  // Block FSM: gather four XORed words, then replay them downstream; bad-round blocks are swallowed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_word_idx  <= 2'd0;
      r_emit_idx  <= 2'd0;
      r_round_q   <= 4'd0;
      r_buf       <= '0;
      r_drop_q    <= 1'b0;
      r_err_round <= 1'b0;
    end else begin
      r_err_round <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_round_q  <= in_round;
            r_word_idx <= 2'd1;
            r_state    <= ACCEPT;
            if (in_round > NR_W) begin
              r_drop_q    <= 1'b1;
              r_err_round <= 1'b1;
            end else begin
              r_drop_q <= 1'b0;
              r_buf[0] <= in_word ^ key_word;
            end
          end
        end
        ACCEPT: begin
          if (w_take) begin
            if (!r_drop_q) begin
              r_buf[r_word_idx] <= in_word ^ key_word;
            end
            r_word_idx <= r_word_idx + 2'd1;
            if (r_word_idx == 2'd3) begin
              r_state  <= r_drop_q ? IDLE : EMIT;
              r_drop_q <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            r_emit_idx <= r_emit_idx + 2'd1;
            if (r_emit_idx == 2'd3) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ark_stage.sv
// tb/tb_aes_ark_stage.sv - scoreboard bench for aes_ark_stage with directed FIPS-197 vectors
module tb_aes_ark_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [3:0]  in_round;
  logic        key_done;
  logic [3:0]  key_round_num;
  logic [1:0]  key_r_index;
  logic [31:0] key_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
  logic        err_round;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;

  logic [32:0]  exp_q[$];
  logic [127:0] rk [0:15];

  localparam logic [127:0] ST_B   = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] EXP_B  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] ST_C   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KEY_C  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] EXP_C  = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
  localparam logic [127:0] EXP_B1 = 128'hcdbc0957_77a5cf72_cece675d_1fc8f8cb;

  aes_ark_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_round(in_round),
    .key_done(key_done), .key_round_num(key_round_num), .key_r_index(key_r_index),
    .key_word(key_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_last(out_last), .err_round(err_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expander model: round-key table addressed by round and word select.
  assign key_word = (key_round_num <= 4'd10) ? rk[key_round_num][{key_r_index, 5'b0} +: 32] : 32'hdeadbeef;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %0h last %0b with nothing expected", out_word, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_word, out_last} !== e) begin
          errors++;
          $display("FAIL out_word: got %0h last %0b expected %0h last %0b", out_word, out_last, e[32:1], e[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (err_round === 1'b1) err_cnt++;
  end

  task automatic push_blk(input logic [127:0] e);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = e[127 - 32*i -: 32];
      exp_q.push_back({w, (i == 3)});
    end
  endtask

  task automatic send_blk(input logic [127:0] st, input logic [3:0] rnd, input int nwords,
                          input bit chk_idx, output int c0);
    int n;
    c0 = 0;
    for (int i = 0; i < nwords; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = st[127 - 32*i -: 32];
      in_round = rnd;
      #1;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (in_ready !== 1'b1) begin
        chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      end
      if (i == 0) c0 = cyc;
      if (chk_idx) begin
        chk("key_r_index", {62'd0, key_r_index}, 64'(3 - i));
        chk("key_round_num", {60'd0, key_round_num}, {60'd0, rnd});
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_last"}, {63'd0, out_last}, 64'd0);
    chk({tag, "_err_round"}, {63'd0, err_round}, 64'd0);
    chk({tag, "_key_round_num"}, {60'd0, key_round_num}, 64'd0);
    chk({tag, "_key_r_index"}, {62'd0, key_r_index}, 64'd3);
  endtask

  initial begin
    int c0;
    int e0;
    int n;
    for (int i = 0; i < 16; i++) rk[i] = {4{8'(i), 8'h5a, 8'(i), 8'ha5}};
    rk[1]     = {128{1'b1}};
    rk[0]     = KEY_B;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    in_round  = 4'd0;
    key_done  = 1'b1;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    reset = 1'b0;

    // FIPS-197 App.B round 0
    push_blk(EXP_B);
    send_blk(ST_B, 4'd0, 4, 1'b0, c0);
    drain();

    // FIPS-197 App.C.1 with key word select sequence
    rk[0] = KEY_C;
    push_blk(EXP_C);
    send_blk(ST_C, 4'd0, 4, 1'b1, c0);
    drain();

    // Non-zero round uses the matching round key
    push_blk(EXP_B1);
    send_blk(ST_B, 4'd1, 4, 1'b1, c0);
    drain();

    // Backpressure held on output word 1
    push_blk(EXP_C);
    send_blk(ST_C, 4'd0, 4, 1'b0, c0);
    #1;
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_out_word", {32'd0, out_word}, 64'h40506070);
      chk("bp_out_last", {63'd0, out_last}, 64'd0);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();

    // key_done low stalls intake; latency measured from word 0 handshake
    rk[0]    = KEY_B;
    key_done = 1'b0;
    push_blk(EXP_B);
    fork
      send_blk(ST_B, 4'd0, 4, 1'b0, c0);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          #1;
          chk("kd_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        key_done = 1'b1;
      end
    join
    n = 0;
    #1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(cyc - c0), 64'd4);
    drain();

    // Out-of-range round: error pulse, block swallowed
    e0 = err_cnt;
    send_blk(ST_B, 4'd11, 4, 1'b0, c0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("drop_out_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end
    chk("err_pulses", 64'(err_cnt - e0), 64'd1);
    push_blk(EXP_B);
    send_blk(ST_B, 4'd0, 4, 1'b0, c0);
    drain();

    // Reset after word 2 discards the partial block
    rk[0] = KEY_C;
    send_blk(ST_C, 4'd0, 3, 1'b0, c0);
    in_round = 4'd0;
    reset    = 1'b1;
    #1;
    chk_reset_outs("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_blk(EXP_C);
    send_blk(ST_C, 4'd0, 4, 1'b0, c0);
    drain();

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
